cpu_run_ctrl: RTL

//  Parametrised run controller for the single-cycle RISC-V CPU in simulation and FPGA bring-up.
//  - Sequences CPU reset for a programmable number of cycles, then lets the CPU run.
//  - Ends the run on a store to a "tohost" address (pass/fail with exit code) or on a cycle timeout.
//  - Freezes the CPU and reports status; replaces fixed-delay reset/finish stimulus.

---
 rtl/cpu_run_ctrl_if.sv | 36 +++
 rtl/cpu_run_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Purpose : CPU data-memory / program-counter observation bus that the run
//           controller monitors.
// Signals :
//   MemWrite   CPU data-memory write enable
//   ALUResult  CPU data-memory address
//   WriteData  CPU data-memory write data
//   PC         CPU program counter
// Modports :
//   master  the CPU side (drives the bus)
//   slave   the run controller (observes the bus)
// Handshake : there is no valid/ready pair. The bus is sampled on every rising
//   clock edge; MemWrite alone qualifies ALUResult/WriteData as a store in that
//   cycle. The observer never back-pressures the CPU.
// -----------------------------------------------------------------------------
interface cpu_run_ctrl_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] PC;

  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    output PC
  );

  modport slave (
    input MemWrite,
    input ALUResult,
    input WriteData,
    input PC
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Purpose : Run controller for the single-cycle RISC-V CPU. Holds the CPU in
//           reset for RST_CYCLES cycles, lets it run, and ends the run on a
//           store to TOHOST_ADDR (pass/fail + exit code) or on a cycle timeout.
//           Once finished the CPU is frozen in reset and status is held until
//           rst.
// Ports   :
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          cpu_run_ctrl_if.slave: MemWrite, ALUResult, WriteData, PC
//   cpu_rst      reset to CPU (registered)
//   done         run finished (sticky until rst)
//   pass         run finished with PASS_VALUE
//   timeout      run finished due to MAX_CYCLES (or hang)
//   exit_code    WriteData of the terminating tohost store (PC on hang)
//   cycle_count  RUN cycles elapsed, frozen when done, saturating
//   state_dbg    current FSM state encoding (HOLD=0 RUN=1 PASS=2 FAIL=3 TIMEOUT=4)
// Configuration :
//   CPU_RUN_CTRL_HANG_DETECT_EN  when defined, PC unchanged for HANG_CYCLES
//   consecutive RUN cycles ends the run as TIMEOUT with exit_code=PC.
//   Priority: tohost > hang > MAX_CYCLES. When undefined, PC is ignored.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int          RST_CYCLES  = 1,
  parameter int          MAX_CYCLES  = 40,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC,
  parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
  parameter int          CNT_W       = 32,
  parameter int          HANG_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  cpu_run_ctrl_if.slave      bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [31:0]        exit_code,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [2:0]         state_dbg
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [31:0]       exit_code_q, exit_code_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  logic              tohost_hit;
  logic              hang_hit;

`ifdef CPU_RUN_CTRL_HANG_DETECT_EN
  localparam int HANG_W = $clog2(HANG_CYCLES + 1);

  logic [31:0]       last_pc_q, last_pc_d;
  logic [HANG_W-1:0] same_cnt_q, same_cnt_d;
  logic [HANG_W-1:0] run_len;

  // run_len = number of consecutive RUN cycles (including this one) that have
  // shown the current PC. same_cnt_q==0 means no history yet, so the first RUN
  // cycle always starts a fresh run of length 1.
  always_comb begin
    run_len    = HANG_W'(1);
    last_pc_d  = last_pc_q;
    same_cnt_d = '0;
    if ((same_cnt_q != '0) && (bus.PC == last_pc_q)) begin
      run_len = same_cnt_q + HANG_W'(1);
    end
    hang_hit = (state_q == S_RUN) && (run_len == HANG_W'(HANG_CYCLES));
    if (state_q == S_RUN) begin
      last_pc_d  = bus.PC;
      same_cnt_d = run_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q  <= '0;
      same_cnt_q <= '0;
    end else begin
      last_pc_q  <= last_pc_d;
      same_cnt_q <= same_cnt_d;
    end
  end
`else
  // PC is not observed in this build; the reduction is left dangling on purpose.
  logic unused_pc;
  assign unused_pc = ^bus.PC;
  assign hang_hit  = 1'b0;
`endif

  assign tohost_hit = bus.MemWrite && (bus.ALUResult == TOHOST_ADDR);

  // Next-state logic. Status outputs are derived from the next state so they
  // are registered and appear the cycle after the terminating edge.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    exit_code_d   = exit_code_q;

    unique case (state_q)
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end
      end
      S_RUN: begin
        // The terminating cycle is itself counted.
        if (cycle_count_q != {CNT_W{1'b1}}) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (tohost_hit) begin
          exit_code_d = bus.WriteData;
          state_d     = (bus.WriteData == PASS_VALUE) ? S_PASS : S_FAIL;
        end else if (hang_hit) begin
          exit_code_d = bus.PC;
          state_d     = S_TIMEOUT;
        end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d     = S_TIMEOUT;
        end
      end
      default: begin
        // Terminal states hold everything until rst.
      end
    endcase

    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
    pass_d    = (state_d == S_PASS);
    timeout_d = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      exit_code_q   <= '0;
      cpu_rst_q     <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      exit_code_q   <= exit_code_d;
      cpu_rst_q     <= cpu_rst_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;
  assign state_dbg   = state_q;

endmodule
